// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: FSM states, access-size codes and the
// EX/MEM and MEM/WB pipeline register layouts.
package mem_pkg;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] wdata;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  size;
        logic        load_unsigned;
    } exmem_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dst;
        logic        reg_write;
    } memwb_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a 32-bit read word and extends it
// to 32 bits; word loads pass through unchanged.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i32,
    input  logic [1:0]  addr_i2,
    input  logic [1:0]  size_i2,
    input  logic        unsigned_i,
    output logic [31:0] load_data_o32
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v        = rdata_i32[{addr_i2, 3'b000} +: 8];
        half_v        = addr_i2[1] ? rdata_i32[31:16] : rdata_i32[15:0];
        load_data_o32 = rdata_i32;
        case (size_i2)
            SIZE_BYTE: load_data_o32 = unsigned_i ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SIZE_HALF: load_data_o32 = unsigned_i ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default:   load_data_o32 = rdata_i32;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register, data-memory access FSM with timeout, and MEM/WB register.
// Optional sub-word lane steering is enabled by defining MEM_BYTE_LANES_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_out_ie32,
    input  logic [31:0] write_data_ie32,
    input  logic [4:0]  dst_reg_addr_ie5,
    input  logic        reg_write_ie,
    input  logic        mem_to_reg_ie,
    input  logic        mem_read_ie,
    input  logic        mem_write_ie,
    input  logic [1:0]  size_ie2,
    input  logic        load_unsigned_ie,
    input  logic        flush_i,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i32,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o32,
    output logic [31:0] dmem_wdata_o32,
    output logic [3:0]  dmem_be_o4,
    output logic [31:0] alu_out_om32,
    output logic [4:0]  dst_reg_addr_om5,
    output logic        reg_write_om,
    output logic [31:0] res_owb32,
    output logic [4:0]  dst_reg_addr_owb5,
    output logic        reg_write_owb,
    output logic        stall_o,
    output logic        bus_err_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    exmem_t             exmem_q, exmem_d;
    memwb_t             memwb_q, memwb_d;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_err_q, bus_err_d;

    logic               mem_op, abort, stall;
    logic [3:0]         be_lanes;
    logic [31:0]        wdata_lanes, load_data;

    assign mem_op = exmem_q.mem_read | exmem_q.mem_write;
    assign abort  = (state_q == S_WAIT) && (cnt_q == CNT_W'(MAX_WAIT)) && !dmem_ack_i;
    assign stall  = mem_op & ~dmem_ack_i & ~abort;

    always_comb begin
        exmem_d = exmem_q;
        if (!stall) begin
            exmem_d.alu_out       = alu_out_ie32;
            exmem_d.wdata         = write_data_ie32;
            exmem_d.dst           = dst_reg_addr_ie5;
            exmem_d.reg_write     = reg_write_ie & ~flush_i;
            exmem_d.mem_to_reg    = mem_to_reg_ie;
            exmem_d.mem_read      = mem_read_ie & ~flush_i;
            exmem_d.mem_write     = mem_write_ie & ~flush_i;
            exmem_d.size          = size_ie2;
            exmem_d.load_unsigned = load_unsigned_ie;
        end
    end

    // Ack is tested before abort so a last-cycle ack still completes normally.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | abort;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !dmem_ack_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (dmem_ack_i || abort) state_d = S_IDLE;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_BYTE_LANES_EN
    always_comb begin
        be_lanes    = 4'hF;
        wdata_lanes = exmem_q.wdata;
        case (exmem_q.size)
            SIZE_BYTE: begin
                be_lanes    = 4'b0001 << exmem_q.alu_out[1:0];
                wdata_lanes = {4{exmem_q.wdata[7:0]}};
            end
            SIZE_HALF: begin
                be_lanes    = exmem_q.alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{exmem_q.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata_i32     (dmem_rdata_i32),
        .addr_i2       (exmem_q.alu_out[1:0]),
        .size_i2       (exmem_q.size),
        .unsigned_i    (exmem_q.load_unsigned),
        .load_data_o32 (load_data)
    );
`else
    logic unused_lane_cfg;
    assign unused_lane_cfg = ^{exmem_q.size, exmem_q.load_unsigned};
    assign be_lanes    = 4'hF;
    assign wdata_lanes = exmem_q.wdata;
    assign load_data   = dmem_rdata_i32;
`endif

    // A stalled cycle inserts a bubble; an aborted load retires without a write.
    always_comb begin
        memwb_d           = memwb_q;
        memwb_d.reg_write = 1'b0;
        if (!stall) begin
            memwb_d.res       = exmem_q.mem_to_reg ? load_data : exmem_q.alu_out;
            memwb_d.dst       = exmem_q.dst;
            memwb_d.reg_write = exmem_q.reg_write & ~abort;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_q   <= '0;
            memwb_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dmem_req_o        = mem_op & ~abort;
    assign dmem_we_o         = exmem_q.mem_write;
    assign dmem_addr_o32     = {exmem_q.alu_out[31:2], 2'b00};
    assign dmem_wdata_o32    = wdata_lanes;
    assign dmem_be_o4        = dmem_req_o ? be_lanes : 4'h0;
    assign alu_out_om32      = exmem_q.alu_out;
    assign dst_reg_addr_om5  = exmem_q.dst;
    assign reg_write_om      = exmem_q.reg_write;
    assign res_owb32         = memwb_q.res;
    assign dst_reg_addr_owb5 = memwb_q.dst;
    assign reg_write_owb     = memwb_q.reg_write;
    assign stall_o           = stall;
    assign bus_err_o         = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, zero-wait load, waited
// store, timeout abort, flush, sub-word lanes and reset during an access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_out_ie32, write_data_ie32, dmem_rdata_i32;
    logic [4:0]  dst_reg_addr_ie5;
    logic        reg_write_ie, mem_to_reg_ie, mem_read_ie, mem_write_ie;
    logic [1:0]  size_ie2;
    logic        load_unsigned_ie, flush_i, dmem_ack_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o32, dmem_wdata_o32, alu_out_om32, res_owb32;
    logic [3:0]  dmem_be_o4;
    logic [4:0]  dst_reg_addr_om5, dst_reg_addr_owb5;
    logic        reg_write_om, reg_write_owb, stall_o, bus_err_o;

    int tests = 0;
    int fails = 0;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .alu_out_ie32(alu_out_ie32), .write_data_ie32(write_data_ie32),
        .dst_reg_addr_ie5(dst_reg_addr_ie5), .reg_write_ie(reg_write_ie),
        .mem_to_reg_ie(mem_to_reg_ie), .mem_read_ie(mem_read_ie),
        .mem_write_ie(mem_write_ie), .size_ie2(size_ie2),
        .load_unsigned_ie(load_unsigned_ie), .flush_i(flush_i),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i32(dmem_rdata_i32),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o32(dmem_addr_o32), .dmem_wdata_o32(dmem_wdata_o32),
        .dmem_be_o4(dmem_be_o4), .alu_out_om32(alu_out_om32),
        .dst_reg_addr_om5(dst_reg_addr_om5), .reg_write_om(reg_write_om),
        .res_owb32(res_owb32), .dst_reg_addr_owb5(dst_reg_addr_owb5),
        .reg_write_owb(reg_write_owb), .stall_o(stall_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic nop_in();
        alu_out_ie32 = '0; write_data_ie32 = '0; dst_reg_addr_ie5 = '0;
        reg_write_ie = 0; mem_to_reg_ie = 0; mem_read_ie = 0; mem_write_ie = 0;
        size_ie2 = 2'b10; load_unsigned_ie = 0; flush_i = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        alu_out_ie32 = $urandom; write_data_ie32 = $urandom; dst_reg_addr_ie5 = 5'($urandom);
        reg_write_ie = 1; mem_to_reg_ie = 1; mem_read_ie = 1; mem_write_ie = 1;
        size_ie2 = 2'($urandom); load_unsigned_ie = 1'($urandom); flush_i = 0;
        dmem_ack_i = 1'($urandom); dmem_rdata_i32 = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        tests++; if (dmem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", dmem_req_o); end
        tests++; if (dmem_we_o !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", dmem_we_o); end
        tests++; if (dmem_addr_o32 !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", dmem_addr_o32); end
        tests++; if (dmem_wdata_o32 !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", dmem_wdata_o32); end
        tests++; if (dmem_be_o4 !== 4'h0) begin fails++; $display("FAIL reset_be got %h want 0", dmem_be_o4); end
        tests++; if (alu_out_om32 !== 32'h0) begin fails++; $display("FAIL reset_alu_om got %h want 0", alu_out_om32); end
        tests++; if (dst_reg_addr_om5 !== 5'h0) begin fails++; $display("FAIL reset_dst_om got %h want 0", dst_reg_addr_om5); end
        tests++; if (reg_write_om !== 1'b0) begin fails++; $display("FAIL reset_rw_om got %b want 0", reg_write_om); end
        tests++; if (res_owb32 !== 32'h0) begin fails++; $display("FAIL reset_res got %h want 0", res_owb32); end
        tests++; if (dst_reg_addr_owb5 !== 5'h0) begin fails++; $display("FAIL reset_dst_owb got %h want 0", dst_reg_addr_owb5); end
        tests++; if (reg_write_owb !== 1'b0) begin fails++; $display("FAIL reset_rw_owb got %b want 0", reg_write_owb); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall_o); end
        tests++; if (bus_err_o !== 1'b0) begin fails++; $display("FAIL reset_bus_err got %b want 0", bus_err_o); end
        reset = 0; nop_in(); dmem_ack_i = 0;
    endtask

    task automatic test_lw_zero_wait();
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h100; dst_reg_addr_ie5 = 5'd5; reg_write_ie = 1; mem_to_reg_ie = 1; mem_read_ie = 1;
        @(negedge clk); nop_in(); dmem_ack_i = 1; dmem_rdata_i32 = 32'hDEADBEEF; #1;
        tests++; if (dmem_req_o !== 1'b1) begin fails++; $display("FAIL lw_req got %b want 1", dmem_req_o); end
        tests++; if (dmem_we_o !== 1'b0) begin fails++; $display("FAIL lw_we got %b want 0", dmem_we_o); end
        tests++; if (dmem_addr_o32 !== 32'h100) begin fails++; $display("FAIL lw_addr got %h want 100", dmem_addr_o32); end
        tests++; if (dmem_be_o4 !== 4'hF) begin fails++; $display("FAIL lw_be got %h want f", dmem_be_o4); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL lw_stall got %b want 0", stall_o); end
        @(negedge clk); dmem_ack_i = 0; #1;
        tests++; if (res_owb32 !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_res got %h want deadbeef", res_owb32); end
        tests++; if (reg_write_owb !== 1'b1) begin fails++; $display("FAIL lw_rw_owb got %b want 1", reg_write_owb); end
        tests++; if (dst_reg_addr_owb5 !== 5'd5) begin fails++; $display("FAIL lw_dst_owb got %0d want 5", dst_reg_addr_owb5); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL lw_stall_after got %b want 0", stall_o); end
    endtask

    task automatic test_sw_wait();
        int nstall = 0;
        logic exp_stall;
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h104; write_data_ie32 = 32'hCAFEF00D; mem_write_ie = 1;
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h77; dst_reg_addr_ie5 = 5'd9; reg_write_ie = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            dmem_ack_i = (k == 3); #1;
            exp_stall = (k < 3);
            if (stall_o === 1'b1) nstall++;
            tests++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin fails++; $display("FAIL sw_req_we k=%0d got %b%b want 11", k, dmem_req_o, dmem_we_o); end
            tests++; if (dmem_addr_o32 !== 32'h104) begin fails++; $display("FAIL sw_addr k=%0d got %h want 104", k, dmem_addr_o32); end
            tests++; if (dmem_wdata_o32 !== 32'hCAFEF00D) begin fails++; $display("FAIL sw_wdata k=%0d got %h want cafef00d", k, dmem_wdata_o32); end
            tests++; if (alu_out_om32 !== 32'h104) begin fails++; $display("FAIL sw_hold k=%0d got %h want 104", k, alu_out_om32); end
            tests++; if (stall_o !== exp_stall) begin fails++; $display("FAIL sw_stall k=%0d got %b want %b", k, stall_o, exp_stall); end
            if (k > 0) begin
                tests++; if (reg_write_owb !== 1'b0) begin fails++; $display("FAIL sw_bubble k=%0d got %b want 0", k, reg_write_owb); end
            end
        end
        @(negedge clk); nop_in(); dmem_ack_i = 0; #1;
        tests++; if (nstall != 3) begin fails++; $display("FAIL sw_stall_count got %0d want 3", nstall); end
        tests++; if (alu_out_om32 !== 32'h77 || dst_reg_addr_om5 !== 5'd9 || reg_write_om !== 1'b1) begin fails++; $display("FAIL sw_next_load got %h/%0d/%b want 77/9/1", alu_out_om32, dst_reg_addr_om5, reg_write_om); end
        tests++; if (reg_write_owb !== 1'b0) begin fails++; $display("FAIL sw_wb got %b want 0", reg_write_owb); end
        @(negedge clk); #1;
        tests++; if (res_owb32 !== 32'h77 || reg_write_owb !== 1'b1 || dst_reg_addr_owb5 !== 5'd9) begin fails++; $display("FAIL add_wb got %h/%b/%0d want 77/1/9", res_owb32, reg_write_owb, dst_reg_addr_owb5); end
    endtask

    task automatic test_abort();
        logic exp;
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h200; dst_reg_addr_ie5 = 5'd7; reg_write_ie = 1; mem_to_reg_ie = 1; mem_read_ie = 1;
        @(negedge clk); nop_in(); dmem_ack_i = 0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp = (k < 16);
            tests++; if (dmem_req_o !== exp) begin fails++; $display("FAIL abort_req k=%0d got %b want %b", k, dmem_req_o, exp); end
            tests++; if (stall_o !== exp) begin fails++; $display("FAIL abort_stall k=%0d got %b want %b", k, stall_o, exp); end
            tests++; if (bus_err_o !== 1'b0) begin fails++; $display("FAIL abort_err_early k=%0d got %b want 0", k, bus_err_o); end
            if (k > 0) begin
                tests++; if (reg_write_owb !== 1'b0) begin fails++; $display("FAIL abort_bubble k=%0d got %b want 0", k, reg_write_owb); end
            end
        end
        @(negedge clk); #1;
        tests++; if (bus_err_o !== 1'b1) begin fails++; $display("FAIL abort_err got %b want 1", bus_err_o); end
        tests++; if (reg_write_owb !== 1'b0) begin fails++; $display("FAIL abort_rw_owb got %b want 0", reg_write_owb); end
        tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL abort_after got %b%b want 00", dmem_req_o, stall_o); end
        repeat (3) @(negedge clk);
        #1;
        tests++; if (bus_err_o !== 1'b1) begin fails++; $display("FAIL abort_sticky got %b want 1", bus_err_o); end
    endtask

    task automatic test_flush();
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h5; dst_reg_addr_ie5 = 5'd3; reg_write_ie = 1;
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h300; dst_reg_addr_ie5 = 5'd4; reg_write_ie = 1; mem_read_ie = 1; mem_to_reg_ie = 1;
        flush_i = 1; dmem_ack_i = 1; #1;
        tests++; if (alu_out_om32 !== 32'h5 || reg_write_om !== 1'b1 || dst_reg_addr_om5 !== 5'd3) begin fails++; $display("FAIL flush_add got %h/%b/%0d want 5/1/3", alu_out_om32, reg_write_om, dst_reg_addr_om5); end
        tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL stray_ack got %b%b want 00", dmem_req_o, stall_o); end
        @(negedge clk); nop_in(); dmem_ack_i = 0; #1;
        tests++; if (alu_out_om32 !== 32'h300) begin fails++; $display("FAIL flush_alu got %h want 300", alu_out_om32); end
        tests++; if (reg_write_om !== 1'b0 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL flush_slot got rw=%b req=%b stall=%b want 000", reg_write_om, dmem_req_o, stall_o); end
        tests++; if (res_owb32 !== 32'h5 || reg_write_owb !== 1'b1 || dst_reg_addr_owb5 !== 5'd3) begin fails++; $display("FAIL flush_add_wb got %h/%b/%0d want 5/1/3", res_owb32, reg_write_owb, dst_reg_addr_owb5); end
        @(negedge clk); #1;
        tests++; if (reg_write_owb !== 1'b0) begin fails++; $display("FAIL flush_wb got %b want 0", reg_write_owb); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp_res;
        for (int u = 0; u < 2; u++) begin
            @(negedge clk); nop_in();
            alu_out_ie32 = 32'h103; dst_reg_addr_ie5 = 5'd2; reg_write_ie = 1; mem_to_reg_ie = 1; mem_read_ie = 1;
            size_ie2 = 2'b00; load_unsigned_ie = 1'(u);
            @(negedge clk); nop_in(); dmem_ack_i = 1; dmem_rdata_i32 = 32'h80123456; #1;
`ifdef MEM_BYTE_LANES_EN
            tests++; if (dmem_be_o4 !== 4'b1000) begin fails++; $display("FAIL lb_be u=%0d got %b want 1000", u, dmem_be_o4); end
            exp_res = (u == 1) ? 32'h00000080 : 32'hFFFFFF80;
`else
            tests++; if (dmem_be_o4 !== 4'hF) begin fails++; $display("FAIL lb_be u=%0d got %b want 1111", u, dmem_be_o4); end
            exp_res = 32'h80123456;
`endif
            tests++; if (dmem_addr_o32 !== 32'h100) begin fails++; $display("FAIL lb_addr u=%0d got %h want 100", u, dmem_addr_o32); end
            @(negedge clk); dmem_ack_i = 0; #1;
            tests++; if (res_owb32 !== exp_res) begin fails++; $display("FAIL lb_res u=%0d got %h want %h", u, res_owb32, exp_res); end
        end
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h101; write_data_ie32 = 32'h000000AB; mem_write_ie = 1; size_ie2 = 2'b00;
        @(negedge clk); nop_in(); dmem_ack_i = 1; #1;
`ifdef MEM_BYTE_LANES_EN
        tests++; if (dmem_be_o4 !== 4'b0010 || dmem_wdata_o32 !== 32'hABABABAB) begin fails++; $display("FAIL sb_lanes got %b/%h want 0010/abababab", dmem_be_o4, dmem_wdata_o32); end
`else
        tests++; if (dmem_be_o4 !== 4'hF || dmem_wdata_o32 !== 32'h000000AB) begin fails++; $display("FAIL sb_lanes got %b/%h want 1111/000000ab", dmem_be_o4, dmem_wdata_o32); end
`endif
        @(negedge clk); dmem_ack_i = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); nop_in();
        alu_out_ie32 = 32'h400; dst_reg_addr_ie5 = 5'd1; reg_write_ie = 1; mem_read_ie = 1; mem_to_reg_ie = 1;
        @(negedge clk); nop_in(); dmem_ack_i = 0; #1;
        tests++; if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin fails++; $display("FAIL mid_pending got %b%b want 11", dmem_req_o, stall_o); end
        @(negedge clk); reset = 1;
        @(negedge clk); #1;
        tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL mid_req got %b%b want 00", dmem_req_o, stall_o); end
        tests++; if (bus_err_o !== 1'b0 || reg_write_owb !== 1'b0) begin fails++; $display("FAIL mid_clear got err=%b rw=%b want 00", bus_err_o, reg_write_owb); end
        reset = 0;
    endtask

    initial begin
        nop_in(); dmem_ack_i = 0; dmem_rdata_i32 = '0; reset = 1;
        test_reset();
        test_lw_zero_wait();
        test_sw_wait();
        test_abort();
        test_flush();
        test_byte_lanes();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
